// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet injector: flit type codes, field
// positions, FSM states and the unpacked flit field bundle.
package noc_pkg;

  localparam int unsigned TYPE_W   = 2;
  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned SEQ_LSB  = 8;
  localparam int unsigned SRC_LSB  = 4;
  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned IDX_LSB  = 0;

  localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b00;
  localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b01;
  localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b10;
  localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } inj_state_t;

  typedef struct packed {
    logic [TYPE_W-1:0] ftype;
    logic [SEQ_W-1:0]  seq;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   dest;
    logic [IDX_W-1:0]  idx;
  } flit_fields_t;

  // Type of the flit at position idx in a packet whose last index is last_idx.
  function automatic logic [TYPE_W-1:0] flit_type(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] last_idx);
    logic [TYPE_W-1:0] t;
    if (last_idx == '0)      t = FLIT_SINGLE;
    else if (idx == '0)      t = FLIT_HEAD;
    else if (idx == last_idx) t = FLIT_TAIL;
    else                     t = FLIT_BODY;
    return t;
  endfunction

endpackage

// File: rtl/noc_flit_builder.sv
// Combinational flit formatter: packs type/seq and either src+dest (head,
// single) or the flit index (body, tail) into one data word.
module noc_flit_builder
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  flit_fields_t           fields,
  output logic [DATA_WIDTH-1:0]  data_c
);

  always_comb begin
    data_c = '0;
    data_c[DATA_WIDTH-1 -: TYPE_W] = fields.ftype;
    data_c[SEQ_LSB +: SEQ_W]       = fields.seq;
    if (fields.ftype == FLIT_HEAD || fields.ftype == FLIT_SINGLE) begin
      data_c[SRC_LSB +: ID_W]  = fields.src;
      data_c[DEST_LSB +: ID_W] = fields.dest;
    end else begin
      data_c[IDX_LSB +: IDX_W] = fields.idx;
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Per-node NoC traffic source: on start, sends NUM_PKTS packets of PKT_FLITS
// flits to a latched destination over a valid/ready channel, with idle gaps.
module noc_packet_injector
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned NUM_NODES  = 8,
  parameter int unsigned PKT_FLITS  = 6,
  parameter int unsigned NUM_PKTS   = 5,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned DEST_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DEST_W-1:0]     dest,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pkt_count
);

  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_FLITS - 1);
  localparam logic [7:0]       LAST_PKT = 8'(NUM_PKTS - 1);

  inj_state_t        state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        pkt_count_d;
  logic              valid_d, busy_d, done_d;
  flit_fields_t      fields;
  logic [DATA_WIDTH-1:0] flit_c;

  // pkt_count doubles as the sequence number of the packet being sent.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    pkt_count_d = pkt_count;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SEND;
          dest_d      = dest;
          idx_d       = '0;
          pkt_count_d = '0;
        end
      end
      ST_SEND: begin
        if (valid && ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            pkt_count_d = pkt_count + 8'd1;
            if (pkt_count == LAST_PKT) begin
              state_d = ST_DONE;
            end else if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_W'(GAP_LOAD);
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_SEND;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    fields.ftype = flit_type(idx_d, LAST_IDX);
    fields.seq   = pkt_count_d;
    fields.src   = ID_W'(NODE_ID);
    fields.dest  = ID_W'(dest_d);
    fields.idx   = idx_d;

    valid_d = (state_d == ST_SEND);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  noc_flit_builder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_flit_builder (
    .fields (fields),
    .data_c (flit_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      pkt_count <= '0;
      valid     <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pkt_count <= pkt_count_d;
      valid     <= valid_d;
      data      <= valid_d ? flit_c : '0;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Randomized bench for noc_packet_injector: three configurations checked
// against a flit-list model derived from the packet format rules.
module tb_noc_packet_injector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default configuration
  logic        rst_a, start_a, ready_a, valid_a, busy_a, done_a;
  logic [2:0]  dest_a;
  logic [31:0] data_a;
  logic [7:0]  pkt_count_a;
  // Instance B: single-flit packets, no gap
  logic        rst_b, start_b, ready_b, valid_b, busy_b, done_b;
  logic [2:0]  dest_b;
  logic [31:0] data_b;
  logic [7:0]  pkt_count_b;
  // Instance C: 256 packets, sequence wrap
  logic        rst_c, start_c, ready_c, valid_c, busy_c, done_c;
  logic [3:0]  dest_c;
  logic [31:0] data_c;
  logic [7:0]  pkt_count_c;

  noc_packet_injector u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .dest(dest_a), .data(data_a),
    .valid(valid_a), .ready(ready_a), .busy(busy_a), .done(done_a), .pkt_count(pkt_count_a)
  );

  noc_packet_injector #(.NODE_ID(7), .PKT_FLITS(1), .NUM_PKTS(3), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .dest(dest_b), .data(data_b),
    .valid(valid_b), .ready(ready_b), .busy(busy_b), .done(done_b), .pkt_count(pkt_count_b)
  );

  noc_packet_injector #(.NODE_ID(10), .NUM_NODES(16), .PKT_FLITS(2), .NUM_PKTS(256),
                        .GAP_CYCLES(0)) u_dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .dest(dest_c), .data(data_c),
    .valid(valid_c), .ready(ready_c), .busy(busy_c), .done(done_c), .pkt_count(pkt_count_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected word for flit f of packet p.
  function automatic logic [31:0] model_flit(input int pf, input int node, input int dst,
                                             input int p, input int f);
    logic [31:0] w;
    logic [1:0]  t;
    if (pf == 1)           t = 2'b11;
    else if (f == 0)       t = 2'b01;
    else if (f == pf - 1)  t = 2'b10;
    else                   t = 2'b00;
    w = {t, 30'd0} | 32'((p % 256) * 256);
    if (f == 0) w = w | 32'(node * 16 + dst);
    else        w = w | 32'(f);
    return w;
  endfunction

  task automatic cmp_burst(input string tag, input logic [31:0] q[$], input int pf,
                           input int np, input int node, input int dst);
    check({tag, "_count"}, q.size(), pf * np);
    for (int p = 0; p < np; p++)
      for (int f = 0; f < pf; f++)
        if (p * pf + f < q.size())
          check({tag, "_flit"}, q[p * pf + f], model_flit(pf, node, dst, p, f));
  endtask

  // Monitors sample on the falling edge.
  logic [31:0] acc_a[$], acc_b[$], acc_c[$];
  int first_a = -1, last_a = 0, vcnt_a = 0, done_cnt_a = 0, cyc_a = 0;
  int vcnt_b = 0, done_cnt_b = 0;
  int done_cnt_c = 0, done_acc_c = 0;
  logic        stall_a = 1'b0, stall_c = 1'b0;
  logic [31:0] held_a = '0, held_c = '0;

  initial forever begin
    @(negedge clk);
    cyc_a++;
    if (stall_a && rst_a) begin
      check("hold_valid_a", 32'(valid_a), 32'd1);
      check("hold_data_a", data_a, held_a);
    end
    stall_a = valid_a && !ready_a && rst_a;
    held_a  = data_a;
    if (valid_a && ready_a) begin
      acc_a.push_back(data_a);
      if (first_a < 0) first_a = cyc_a;
      last_a = cyc_a;
    end
    if (valid_a) vcnt_a++;
    if (done_a) done_cnt_a++;
  end

  initial forever begin
    @(negedge clk);
    if (valid_b && ready_b) acc_b.push_back(data_b);
    if (valid_b) vcnt_b++;
    if (done_b) done_cnt_b++;
  end

  initial forever begin
    @(negedge clk);
    if (stall_c && rst_c) begin
      check("hold_valid_c", 32'(valid_c), 32'd1);
      check("hold_data_c", data_c, held_c);
    end
    stall_c = valid_c && !ready_c && rst_c;
    held_c  = data_c;
    if (valid_c && ready_c) acc_c.push_back(data_c);
    if (done_c) begin
      done_cnt_c++;
      done_acc_c = acc_c.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int done_of(input int which);
    case (which)
      0:       return done_cnt_a;
      1:       return done_cnt_b;
      default: return done_cnt_c;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Drive random ready on one instance until its done pulse, bounded.
  task automatic run_wait(input int which, input int max_cyc, input int unsigned pct);
    int   d0;
    int   n;
    logic r;
    d0 = done_of(which);
    n  = 0;
    while (done_of(which) == d0 && n < max_cyc) begin
      step();
      r = ($urandom_range(99) < pct);
      case (which)
        0:       ready_a = r;
        1:       ready_b = r;
        default: ready_c = r;
      endcase
      n++;
    end
    check("done_seen", 32'(done_of(which) != d0), 32'd1);
    repeat (3) step();
    check("done_once", done_of(which) - d0, 1);
    check("idle_after", 32'(busy_of(which)), 32'd0);
    ready_a = 1'b1;
    ready_b = 1'b1;
    ready_c = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    dest_a = '0; dest_b = '0; dest_c = '0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) step();

    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_data", data_a, 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pkt_count", 32'(pkt_count_a), 32'd0);
    check("rst_valid_c", 32'(valid_c), 32'd0);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    step();

    // Burst with ready high, plus a start/dest=5 pulse that must be ignored
    acc_a.delete(); first_a = -1; vcnt_a = 0;
    dest_a = 3'd3; start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("start_busy", 32'(busy_a), 32'd1);
    repeat (4) step();
    dest_a = 3'd5; start_a = 1'b1;
    step();
    start_a = 1'b0; dest_a = 3'd0;
    run_wait(0, 400, 100);
    cmp_burst("t1", acc_a, 6, 5, 0, 3);
    check("t1_span", last_a - first_a + 1, 38);
    check("t1_valid_cycles", vcnt_a, 30);
    check("t1_pkt_count", 32'(pkt_count_a), 32'd5);

    // Random backpressure and random destinations
    for (int k = 0; k < 2; k++) begin
      d = int'($urandom_range(7));
      acc_a.delete(); first_a = -1; vcnt_a = 0;
      dest_a = 3'(d); start_a = 1'b1;
      step();
      start_a = 1'b0; dest_a = 3'($urandom_range(7));
      run_wait(0, 1000, 50);
      cmp_burst("t2", acc_a, 6, 5, 0, d);
      check("t2_pkt_count", 32'(pkt_count_a), 32'd5);
    end

    // Reset in the middle of the second packet, then restart
    acc_a.delete(); first_a = -1; vcnt_a = 0;
    dest_a = 3'd6; start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 0;
    while (acc_a.size() < 9 && n < 100) begin
      step();
      n++;
    end
    check("rst_reach", 32'(acc_a.size() >= 9), 32'd1);
    check("pre_rst_pkt_count", 32'(pkt_count_a), 32'd1);
    rst_a = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    check("mid_rst_pkt_count", 32'(pkt_count_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_data", data_a, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    step();
    acc_a.delete(); first_a = -1; vcnt_a = 0;
    dest_a = 3'd2; start_a = 1'b1;
    step();
    start_a = 1'b0;
    run_wait(0, 400, 100);
    cmp_burst("t3", acc_a, 6, 5, 0, 2);

    // Single-flit packets back to back
    acc_b.delete(); vcnt_b = 0;
    dest_b = 3'd2; start_b = 1'b1;
    step();
    start_b = 1'b0;
    run_wait(1, 100, 100);
    cmp_burst("tb", acc_b, 1, 3, 7, 2);
    check("tb_valid_cycles", vcnt_b, 3);
    check("tb_pkt_count", 32'(pkt_count_b), 32'd3);

    // 256 packets: sequence and pkt_count wrap
    acc_c.delete();
    dest_c = 4'hC; start_c = 1'b1;
    step();
    start_c = 1'b0;
    run_wait(2, 5000, 70);
    cmp_burst("tc", acc_c, 2, 256, 10, 12);
    if (acc_c.size() == 512) check("tc_last_head_seq", 32'(acc_c[510][15:8]), 32'hFF);
    check("tc_done_after", done_acc_c, 512);
    check("tc_pkt_count", 32'(pkt_count_c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
